// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
package rv32i_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] INSTR_NOP     = 32'h00000013;
    localparam int unsigned IFQ_DEPTH_DEF = 4;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of fetch entries with flush and occupancy count.
module ifq_fifo
    import rv32i_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  fetch_entry_t    wdata,
    input  logic            pop,
    output fetch_entry_t    rdata,
    output logic [CntW-1:0] count
);

    fetch_entry_t    mem [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr_q] <= wdata;
    end

    // Empty reads as zero so the head never exposes stale storage.
    assign rdata = (count_q == '0) ? '0 : mem[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues imem requests, tracks in-flight fetches, queues results.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_queue
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH     = IFQ_DEPTH_DEF,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_current,
    input  logic        pc_flush,
    output logic        pc_write,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        if_ready
);

    localparam int unsigned QCntW = $clog2(DEPTH) + 1;
    localparam int unsigned PCntW = $clog2(MAX_OUTST) + 1;

    logic             started_q;
    logic [1:0]       outst_q, outst_d;
    logic [1:0]       drop_q, drop_d;

    logic             accept, rsp, rsp_keep;
    logic             q_valid, q_push, q_pop;
    logic             byp_valid, byp_take;
    logic [QCntW-1:0] q_count;
    fetch_entry_t     q_wdata, q_rdata;
    fetch_entry_t     pend_wdata, pend_rdata;
    logic [PCntW-1:0] pend_count_unused;
    logic [31:0]      pend_instr_unused;

    // Credit check reserves a queue slot for every request in flight.
    assign imem_req  = started_q & ~pc_flush & (32'(outst_q) < MAX_OUTST)
                     & ((32'(q_count) + 32'(outst_q)) < DEPTH);
    assign accept    = imem_req & imem_gnt;
    assign pc_write  = accept;
    assign pc_next   = pc_current + 32'd4;
    assign imem_addr = {pc_current[31:2], 2'b00};

    // Responses with nothing outstanding are protocol errors and are ignored.
    assign rsp      = imem_rvalid & (outst_q != 2'd0);
    assign rsp_keep = rsp & (drop_q == 2'd0);
    assign q_valid  = (q_count != '0);

`ifdef IFQ_BYPASS_EN
    assign byp_valid = rsp_keep & ~q_valid;
`else
    assign byp_valid = 1'b0;
`endif
    assign byp_take = byp_valid & if_ready;

    assign q_push = rsp_keep & ~byp_take & ~pc_flush;
    assign q_pop  = q_valid & if_ready;

    assign pend_wdata = '{pc: pc_current, instr: INSTR_NOP};
    assign q_wdata    = '{pc: pend_rdata.pc, instr: imem_rdata};
    assign pend_instr_unused = pend_rdata.instr;

    assign if_valid = q_valid | byp_valid;
    assign if_pc    = byp_valid ? pend_rdata.pc : q_rdata.pc;
    assign if_instr = byp_valid ? imem_rdata    : q_rdata.instr;

    always_comb begin
        outst_d = outst_q + 2'(accept) - 2'(rsp);
        drop_d  = drop_q;
        // Everything still in flight after a redirect is stale.
        if (pc_flush) begin
            drop_d = outst_q - 2'(rsp);
        end else if (rsp && (drop_q != 2'd0)) begin
            drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started_q <= 1'b0;
            outst_q   <= 2'd0;
            drop_q    <= 2'd0;
        end else begin
            started_q <= 1'b1;
            outst_q   <= outst_d;
            drop_q    <= drop_d;
        end
    end

    ifq_fifo #(
        .Depth (MAX_OUTST)
    ) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (accept),
        .wdata (pend_wdata),
        .pop   (rsp),
        .rdata (pend_rdata),
        .count (pend_count_unused)
    );

    ifq_fifo #(
        .Depth (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (pc_flush),
        .push  (q_push),
        .wdata (q_wdata),
        .pop   (q_pop),
        .rdata (q_rdata),
        .count (q_count)
    );

    rvalid_without_request: assert property (
        @(posedge clk) disable iff (rst) imem_rvalid |-> (outst_q != 2'd0)
    ) else $error("imem_rvalid with no outstanding request");

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: streaming, backpressure, flush, reset, wrap (+ bypass).
module tb_if_fetch_queue;

    logic        clk, rst;
    logic [31:0] pc_current, pc_next, imem_addr, imem_rdata, if_pc, if_instr;
    logic        pc_flush, pc_write, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;
    logic [31:0] flush_pc;
    logic [31:0] pend_q [$];
    int          total = 0;
    int          bad = 0;

    if_fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .pc_current  (pc_current),
        .pc_flush    (pc_flush),
        .pc_write    (pc_write),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_ready    (if_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register the front end closes its loop through.
    always @(posedge clk or posedge rst) begin
        if (rst)           pc_current <= 32'h0;
        else if (pc_flush) pc_current <= flush_pc;
        else if (pc_write) pc_current <= pc_next;
    end

    // Memory returns {16'hDEAD, addr[15:0]} one cycle after grant when rsp is allowed.
    task automatic drive(input logic gnt, input logic rdy, input logic flush, input logic rsp);
        logic [31:0] a;
        imem_gnt = gnt;
        if_ready = rdy;
        pc_flush = flush;
        if (rsp && pend_q.size() > 0) begin
            a = pend_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = {16'hDEAD, a[15:0]};
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
        #1;
    endtask

    task automatic advance();
        if (pc_write) pend_q.push_back(imem_addr);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pend_q.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush_pc = 32'h0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        total++;
        if (if_valid !== 1'b0 || imem_req !== 1'b0 || pc_write !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl got v=%b req=%b pw=%b exp 0 0 0", if_valid, imem_req, pc_write);
        end
        total++;
        if (if_pc !== 32'h0 || if_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_data got pc=%h instr=%h exp 0 0", if_pc, if_instr);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_req got=%b exp=0", imem_req);
        end
        @(posedge clk);
        #1;
        total++;
        if (imem_req !== 1'b1) begin
            bad++;
            $display("FAIL reset_started_req got=%b exp=1", imem_req);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            total++;
            if (pc_write !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                bad++;
                $display("FAIL stream_accept c%0d got pw=%b addr=%h exp 1 %h",
                         k, pc_write, imem_addr, 32'(4 * k));
            end
            if (k >= 2) begin
                e = 32'(4 * (k - 2));
                total++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== {16'hDEAD, e[15:0]}) begin
                    bad++;
                    $display("FAIL stream_out c%0d got v=%b pc=%h instr=%h exp 1 %h %h",
                             k, if_valid, if_pc, if_instr, e, {16'hDEAD, e[15:0]});
                end
            end
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            e = 32'(16 + 4 * k);
            total++;
            if (k < 2 && (if_valid !== 1'b1 || if_pc !== e)) begin
                bad++;
                $display("FAIL stream_drain d%0d got v=%b pc=%h exp 1 %h", k, if_valid, if_pc, e);
            end else if (k == 2 && if_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream_empty got v=%b exp 0", if_valid);
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [11:0] pw_exp;
        logic [31:0] e;
        pw_exp = 12'b1111_1000_1111;  // bit k = expected pc_write in cycle k
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, (k >= 6), 1'b0, 1'b1);
            total++;
            if (pc_write !== pw_exp[k]) begin
                bad++;
                $display("FAIL bp_pc_write c%0d got=%b exp=%b", k, pc_write, pw_exp[k]);
            end
            if (k == 4 || k == 5) begin
                total++;
                if (imem_req !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_full_req c%0d got=%b exp=0", k, imem_req);
                end
            end
            if (k >= 5) begin
                e = (k == 5) ? 32'h0 : 32'(4 * (k - 6));
                total++;
                if (if_valid !== 1'b1 || if_pc !== e || if_instr !== {16'hDEAD, e[15:0]}) begin
                    bad++;
                    $display("FAIL bp_out c%0d got v=%b pc=%h instr=%h exp 1 %h",
                             k, if_valid, if_pc, if_instr, e);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_inflight();
        do_reset();
        flush_pc = 32'h100;
        drive(1'b1, 1'b1, 1'b0, 1'b1); advance();   // accept 0
        drive(1'b1, 1'b1, 1'b0, 1'b1); advance();   // rsp 0, accept 4
        drive(1'b1, 1'b1, 1'b0, 1'b1); advance();   // rsp 4, accept 8
        drive(1'b1, 1'b1, 1'b0, 1'b0); advance();   // accept 12, 8 and 12 in flight
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (imem_req !== 1'b0 || pc_write !== 1'b0) begin
            bad++;
            $display("FAIL flush_req got req=%b pw=%b exp 0 0", imem_req, pc_write);
        end
        advance();
        for (int k = 0; k < 5; k++) begin
            drive((k == 2), 1'b1, 1'b0, 1'b1);
            if (k < 4) begin
                total++;
                if (if_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL flush_stale c%0d got v=%b pc=%h instr=%h exp v=0",
                             k, if_valid, if_pc, if_instr);
                end
            end else begin
                total++;
                if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'hDEAD0100) begin
                    bad++;
                    $display("FAIL flush_first got v=%b pc=%h instr=%h exp 1 00000100 dead0100",
                             if_valid, if_pc, if_instr);
                end
            end
            advance();
        end
    endtask

    task automatic test_flush_same_rvalid();
        do_reset();
        flush_pc = 32'h200;
        drive(1'b1, 1'b1, 1'b0, 1'b0); advance();   // accept 0
        drive(1'b1, 1'b1, 1'b0, 1'b0); advance();   // accept 4, outst 2
        drive(1'b1, 1'b1, 1'b1, 1'b1);              // rsp 0 with flush
        total++;
        if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL flushrv_cycle got req=%b v=%b exp 0 0", imem_req, if_valid);
        end
        advance();
        for (int k = 0; k < 4; k++) begin
            drive((k == 1), 1'b1, 1'b0, 1'b1);
            total++;
            if (k < 3 && if_valid !== 1'b0) begin
                bad++;
                $display("FAIL flushrv_stale c%0d got v=%b pc=%h exp v=0", k, if_valid, if_pc);
            end else if (k == 3 && (if_valid !== 1'b1 || if_pc !== 32'h200)) begin
                bad++;
                $display("FAIL flushrv_first got v=%b pc=%h exp 1 00000200", if_valid, if_pc);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1); advance();   // accept 0
        drive(1'b1, 1'b0, 1'b0, 1'b1); advance();   // rsp 0, accept 4
        drive(1'b1, 1'b0, 1'b0, 1'b1); advance();   // rsp 4, accept 8
        drive(1'b1, 1'b0, 1'b0, 1'b0);              // accept 12 -> outst 2, count 2
        total++;
        if (if_valid !== 1'b1 || pc_write !== 1'b1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre got v=%b pw=%b req=%b exp 1 1 1", if_valid, pc_write, imem_req);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (if_valid !== 1'b0 || pc_write !== 1'b0 || imem_req !== 1'b0 || if_pc !== 32'h0) begin
            bad++;
            $display("FAIL areset_now got v=%b pw=%b req=%b pc=%h exp 0 0 0 0",
                     if_valid, pc_write, imem_req, if_pc);
        end
        pend_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL areset_release_req got=%b exp=0", imem_req);
        end
        advance();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        total++;
        if (pc_write !== 1'b1 || imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL areset_restart got pw=%b addr=%h exp 1 0", pc_write, imem_addr);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_wrap_bypass();
        do_reset();
        flush_pc = 32'hFFFF_FFFC;
        drive(1'b0, 1'b1, 1'b1, 1'b0); advance();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (pc_next !== 32'h0 || imem_addr !== 32'hFFFF_FFFC || pc_write !== 1'b1) begin
            bad++;
            $display("FAIL wrap_pc got next=%h addr=%h pw=%b exp 00000000 fffffffc 1",
                     pc_next, imem_addr, pc_write);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b1);
`ifdef IFQ_BYPASS_EN
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hDEAD_FFFC) begin
            bad++;
            $display("FAIL bypass_same got v=%b pc=%h instr=%h exp 1 fffffffc deadfffc",
                     if_valid, if_pc, if_instr);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL bypass_not_queued got v=%b exp 0", if_valid);
        end
`else
        total++;
        if (if_valid !== 1'b0) begin
            bad++;
            $display("FAIL wrap_latency got v=%b exp 0", if_valid);
        end
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC || if_instr !== 32'hDEAD_FFFC) begin
            bad++;
            $display("FAIL wrap_out got v=%b pc=%h instr=%h exp 1 fffffffc deadfffc",
                     if_valid, if_pc, if_instr);
        end
`endif
        advance();
        flush_pc = 32'h0000_0102;
        drive(1'b0, 1'b1, 1'b1, 1'b0); advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        total++;
        if (imem_addr !== 32'h0000_0100 || pc_next !== 32'h0000_0106) begin
            bad++;
            $display("FAIL misalign got addr=%h next=%h exp 00000100 00000106", imem_addr, pc_next);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_inflight();
        test_flush_same_rvalid();
        test_async_reset();
        test_wrap_bypass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
